pixel_array_readout: RTL and testbench
======================================

// Module: pixel_array_readout
// PURPOSE
//   Reader side of the pixel-array READ/DATA_OUT interface. After a frame has been converted, on START it
//   selects rows one at a time with a one-hot READ, lets the shared column bus settle, captures the
//   whole row, then streams pixels row-major over a valid/ready port to the downstream frame sink.
// PARAMETERS
//   HEIGHT         PixelSensorConfig::PIXEL_ARRAY_HEIGHT  number of rows; width of READ
//   WIDTH          PixelSensorConfig::PIXEL_ARRAY_WIDTH   pixels per row; entries of DATA_IN
//   BITS           PixelSensorConfig::PIXEL_BITS          bits per pixel
//   SETTLE_CYCLES  PixelSensorConfig::READOUT_SETTLE_CYCLES (1)  cycles READ held before capture; >=1
// PORTS
//   CLK          in   1             rising-edge clock
//   RESET_N      in   1             asynchronous reset, active low
//   START        in   1             1-cycle request to read one frame; accepted only in IDLE
//   BUSY         out  1             high from START acceptance until FRAME_DONE cycle inclusive
//   READ         out  HEIGHT        one-hot row select to pixel array; all-zero when not selecting
//   DATA_IN      in   [WIDTH][BITS] column bus from pixel array (its DATA_OUT)
//   PIXEL_OUT    out  BITS          current pixel
//   PIXEL_ROW    out  clog2(HEIGHT) row index of PIXEL_OUT
//   PIXEL_COL    out  clog2(WIDTH)  column index of PIXEL_OUT
//   PIXEL_VALID  out  1             PIXEL_OUT/ROW/COL valid
//   PIXEL_READY  in   1             sink accepts; transfer when VALID && READY at rising edge
//   FRAME_DONE   out  1             1-cycle pulse after the last pixel transfer
// BEHAVIOUR
//   Reset (async, RESET_N=0): state IDLE; READ=0, PIXEL_VALID=0, BUSY=0, FRAME_DONE=0, PIXEL_OUT=0,
//     PIXEL_ROW=0, PIXEL_COL=0, row/col/settle counters=0, row buffer=0. Outputs drop immediately.
//   States: IDLE -> SELECT -> CAPTURE -> STREAM -> (SELECT | DONE) -> IDLE.
//   IDLE: START=1 sampled -> SELECT, row=0, BUSY=1. START in any other state is ignored.
//   SELECT: READ=1<<row; hold SETTLE_CYCLES cycles (settle counter), then -> CAPTURE.
//   CAPTURE: READ still 1<<row; on exit edge row buffer <= DATA_IN, col=0, -> STREAM. READ=0 after.
//   STREAM: PIXEL_VALID=1, PIXEL_OUT=buffer[col], PIXEL_ROW=row, PIXEL_COL=col.
//     Outputs registered, stable while VALID && !READY. On transfer: col<WIDTH-1 -> col+1;
//     col==WIDTH-1 && row<HEIGHT-1 -> row+1, VALID=0, -> SELECT; col==WIDTH-1 && row==HEIGHT-1 -> DONE.
//   DONE: one cycle; FRAME_DONE=1, VALID=0; -> IDLE, BUSY=0 from next cycle. START here is ignored.
//   Latency: first PIXEL_VALID high SETTLE_CYCLES+1 cycles after the edge sampling START.
//   Throughput: 1 pixel/cycle within a row when READY=1; SETTLE_CYCLES+1 bubble cycles between rows.
//   READ is never non-zero outside SELECT/CAPTURE and never has >1 bit set.
//   DATA_IN only sampled at CAPTURE exit; changes at any other time do not affect output.
//   HEIGHT=1 or WIDTH=1: index ports are 1 bit wide and held 0; wrap rules above still hold.
//   Counters never exceed HEIGHT-1 / WIDTH-1; no wrap-around past frame end.
// STRUCTURE
//   PixelSensorConfig package gains: READOUT_SETTLE_CYCLES constant, typedef pixel_t (logic [BITS-1:0]),
//     typedef enum readout_state_t {IDLE, SELECT, CAPTURE, STREAM, DONE}.
//   Sub-module pixel_row_serializer: row buffer + column counter + valid/ready output stage;
//     load, load data, and last-column flag at its interface. Top keeps FSM, row counter, READ decode.
//   Elaboration assertion: SETTLE_CYCLES>=1, HEIGHT>=1, WIDTH>=1.
// TESTING  (HEIGHT=2, WIDTH=2, BITS=8, SETTLE_CYCLES=1; bench models array: DATA_IN follows READ)
//   1 Reset mid-idle and after START: READ=0, PIXEL_VALID=0, BUSY=0, FRAME_DONE=0 immediately on RESET_N=0.
//   2 Rows {0x11,0x22},{0x33,0x44}, READY=1, START pulse -> OUT 0x11(0,0),0x22(0,1),0x33(1,0),0x44(1,1);
//     first VALID 2 cycles after START edge; single FRAME_DONE; READ seen as 01 then 10 only.
//   3 Same, READY low 3 cycles on pixel (0,1) -> 0x22 held stable, no loss/duplication, order kept.
//   4 Bench corrupts DATA_IN to 0xFF after each CAPTURE -> output still 0x11,0x22,0x33,0x44.
//   5 START re-pulsed during STREAM and during DONE -> ignored; exactly 4 pixels, one FRAME_DONE.
//   6 RESET_N low during row-1 STREAM, then START -> restarts at row 0, READ=01, full 4-pixel frame.

Source files
------------

// File: rtl/pixel_array_readout_pkg.sv
// Shared configuration, types and helpers for the pixel-array readout path.
package pixel_array_readout_pkg;

    localparam int unsigned PIXEL_ARRAY_HEIGHT    = 4;
    localparam int unsigned PIXEL_ARRAY_WIDTH     = 4;
    localparam int unsigned PIXEL_BITS            = 8;
    localparam int unsigned READOUT_SETTLE_CYCLES = 1;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        STREAM,
        DONE
    } readout_state_t;

    // Index width that stays at least 1 bit so single-entry dimensions still get a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_row_serializer.sv
// Row buffer plus column counter feeding a valid/ready pixel output stage.
module pixel_row_serializer
    import pixel_array_readout_pkg::*;
#(
    parameter int unsigned WIDTH = PIXEL_ARRAY_WIDTH,
    parameter int unsigned BITS  = PIXEL_BITS,
    localparam int unsigned CW   = idx_width(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [WIDTH-1:0][BITS-1:0]   load_data,
    input  logic                         ready,
    output logic                         valid,
    output logic [BITS-1:0]              pixel,
    output logic [CW-1:0]                col,
    output logic                         last
);

    logic [WIDTH-1:0][BITS-1:0] row_q;
    logic [CW-1:0]              col_q;
    logic                       valid_q;
    logic                       xfer;

    assign xfer  = valid_q && ready;
    assign last  = (col_q == CW'(WIDTH - 1));
    assign valid = valid_q;
    assign col   = col_q;
    // Buffer and column are both registers, so the pixel holds steady during a stall.
    assign pixel = row_q[col_q];

    // Capture the row on load, then step the column on each accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            row_q   <= load_data;
            col_q   <= '0;
            valid_q <= 1'b1;
        end else if (xfer) begin
            if (last) begin
                valid_q <= 1'b0;
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_array_readout.sv
// Frame reader: selects rows one-hot, captures the column bus, streams pixels row-major.
module pixel_array_readout
    import pixel_array_readout_pkg::*;
#(
    parameter int unsigned HEIGHT        = PIXEL_ARRAY_HEIGHT,
    parameter int unsigned WIDTH         = PIXEL_ARRAY_WIDTH,
    parameter int unsigned BITS          = PIXEL_BITS,
    parameter int unsigned SETTLE_CYCLES = READOUT_SETTLE_CYCLES,
    localparam int unsigned RW           = idx_width(HEIGHT),
    localparam int unsigned CW           = idx_width(WIDTH),
    localparam int unsigned SW           = idx_width(SETTLE_CYCLES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic [HEIGHT-1:0]            read,
    input  logic [WIDTH-1:0][BITS-1:0]   data_in,
    output logic [BITS-1:0]              pixel_out,
    output logic [RW-1:0]                pixel_row,
    output logic [CW-1:0]                pixel_col,
    output logic                         pixel_valid,
    input  logic                         pixel_ready,
    output logic                         frame_done
);

    if (SETTLE_CYCLES < 1 || HEIGHT < 1 || WIDTH < 1 || BITS < 1) begin : g_param_check
        $error("pixel_array_readout: SETTLE_CYCLES, HEIGHT, WIDTH and BITS must all be >= 1");
    end

    readout_state_t state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic           load;
    logic           col_last;

    pixel_row_serializer #(
        .WIDTH (WIDTH),
        .BITS  (BITS)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (data_in),
        .ready     (pixel_ready),
        .valid     (pixel_valid),
        .pixel     (pixel_out),
        .col       (pixel_col),
        .last      (col_last)
    );

    // State, row and settle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic and the capture strobe to the serializer.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SELECT;
                    row_d    = '0;
                    settle_d = '0;
                end
            end
            SELECT: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CAPTURE: begin
                load    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (pixel_valid && pixel_ready && col_last) begin
                    if (row_q == RW'(HEIGHT - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = SELECT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row select is only driven while the array is being selected or captured.
    always_comb begin
        read = '0;
        if (state_q == SELECT || state_q == CAPTURE) begin
            read[row_q] = 1'b1;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign pixel_row  = row_q;

endmodule

// File: tb/tb_pixel_array_readout.sv
// Directed bench for pixel_array_readout with a 2x2 array model driven by READ.
module tb_pixel_array_readout;

    localparam int unsigned H = 2;
    localparam int unsigned W = 2;
    localparam int unsigned B = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic [H-1:0]     read;
    logic [W-1:0][B-1:0] data_in;
    logic [B-1:0]     pixel_out;
    logic [0:0]       pixel_row;
    logic [0:0]       pixel_col;
    logic             pixel_valid;
    logic             pixel_ready;
    logic             frame_done;
    logic             corrupt;

    int n_checks;
    int n_errors;

    logic [31:0] got[$];
    logic [1:0]  read_log[$];
    logic [1:0]  last_read;
    int          done_cnt;
    int          bad_read;
    int          stall_err;
    logic        prev_stall;
    logic [31:0] prev_word;

    logic [7:0] exp_pix[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    pixel_array_readout #(
        .HEIGHT        (H),
        .WIDTH         (W),
        .BITS          (B),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .read        (read),
        .data_in     (data_in),
        .pixel_out   (pixel_out),
        .pixel_row   (pixel_row),
        .pixel_col   (pixel_col),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel array model: the selected row drives the column bus.
    always_comb begin
        data_in = corrupt ? {8'hFF, 8'hFF} : '0;
        if (read == 2'b01) data_in = {8'h22, 8'h11};
        if (read == 2'b10) data_in = {8'h44, 8'h33};
    end

    function automatic logic [31:0] word(input logic [0:0] r, input logic [0:0] c,
                                         input logic [7:0] p);
        return {22'd0, r, c, p};
    endfunction

    // Observe transfers, pulses, row selects and stall stability away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            last_read  = '0;
        end else begin
            if (prev_stall &&
                !(pixel_valid && word(pixel_row, pixel_col, pixel_out) == prev_word)) begin
                stall_err++;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_word  = word(pixel_row, pixel_col, pixel_out);
            if (pixel_valid && pixel_ready) got.push_back(word(pixel_row, pixel_col, pixel_out));
            if (frame_done) done_cnt++;
            if ($countones(read) > 1) bad_read++;
            if (read != '0 && read != last_read) read_log.push_back(read);
            last_read = read;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        got.delete();
        read_log.delete();
        done_cnt  = 0;
        bad_read  = 0;
        stall_err = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read"}, 32'(read), 32'h0);
        check({tag, "_valid"}, 32'(pixel_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy && done_cnt > 0) break;
        end
        check("frame_finished", 32'(busy), 32'h0);
    endtask

    task automatic wait_pixel(input int r, input int c);
        int n;
        n = 0;
        while (!(pixel_valid && int'(pixel_row) == r && int'(pixel_col) == c) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_pixel_timeout", 32'(n < 30), 32'h1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                check({tag, "_pix"}, got[i], word(1'(i / 2), 1'(i % 2), exp_pix[i]));
            end
        end
        check({tag, "_frame_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_read_onehot"}, 32'(bad_read), 32'd0);
        check({tag, "_read_rows"}, 32'(read_log.size()), 32'd2);
        if (read_log.size() == 2) begin
            check({tag, "_read_first"}, 32'(read_log[0]), 32'h1);
            check({tag, "_read_second"}, 32'(read_log[1]), 32'h2);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        pixel_ready = 1'b1;
        corrupt     = 1'b0;
        prev_stall  = 1'b0;
        prev_word   = '0;
        last_read   = '0;
        clear_log();
        #1;
        check_idle_outputs("por");
        check("por_pixel", 32'(pixel_out), 32'h0);
        check("por_row", 32'(pixel_row), 32'h0);
        check("por_col", 32'(pixel_col), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset while idle, then reset while selecting a row
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_idle_outputs("rst_idle");
        #1 rst_n = 1'b1;
        pulse_start();
        @(posedge clk); #1;
        check("rst_busy_before", 32'(busy), 32'h1);
        check("rst_read_before", 32'(read), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_active");
        @(posedge clk); #1 rst_n = 1'b1;

        // 2: plain frame, latency from the START edge
        clear_log();
        pulse_start();
        check("lat_sel_valid", 32'(pixel_valid), 32'h0);
        check("lat_sel_read", 32'(read), 32'h1);
        check("lat_sel_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("lat_cap_valid", 32'(pixel_valid), 32'h0);
        check("lat_cap_read", 32'(read), 32'h1);
        @(posedge clk); #1;
        check("lat_first_valid", 32'(pixel_valid), 32'h1);
        check("lat_first_pixel", 32'(pixel_out), 32'h11);
        check("lat_stream_read", 32'(read), 32'h0);
        wait_idle();
        check_frame("basic");

        // 3: backpressure on pixel (0,1)
        clear_log();
        pulse_start();
        wait_pixel(0, 1);
        pixel_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_pixel", 32'(pixel_out), 32'h22);
        end
        pixel_ready = 1'b1;
        wait_idle();
        check_frame("stall");
        check("stall_stable", 32'(stall_err), 32'd0);

        // 4: column bus garbage outside capture must not leak through
        clear_log();
        corrupt = 1'b1;
        pulse_start();
        wait_idle();
        check_frame("corrupt");
        corrupt = 1'b0;

        // 5: START re-pulsed during STREAM and during DONE
        clear_log();
        pulse_start();
        wait_pixel(0, 0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 30 && !frame_done; i++) begin
            @(posedge clk); #1;
        end
        check("restart_in_done", 32'(frame_done), 32'h1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart_busy_after_done", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        #1 check("restart_stays_idle", 32'(busy), 32'h0);
        check_frame("restart");

        // 6: reset during row-1 streaming, then a clean frame
        clear_log();
        pulse_start();
        wait_pixel(1, 0);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst_stream");
        check("rst_stream_row", 32'(pixel_row), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();
        pulse_start();
        check("rst_restart_read", 32'(read), 32'h1);
        wait_idle();
        check_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
